adc_iface: RTL and testbench

- Receive-side counterpart of the DAC output interface: clock master for an I2S/left-justified ADC.
- Generates bck/lrck from clk, deserialises adata into 24-bit samples and presents them on a valid/ready stream with a channel tag.
- Sits between the ADC pins and the DSP input path; a 2-entry output buffer absorbs short consumer stalls.

---
 rtl/adc_iface_pkg.sv | 16 +
 rtl/adc_iface_fifo.sv | 65 ++++++
 rtl/adc_iface.sv | 133 +++++++++++++
 tb/tb_adc_iface.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_iface_pkg.sv
// Shared audio definitions used by both the ADC and DAC serial interfaces:
// serial format codes, default word/slot geometry and channel tags.
package adc_iface_pkg;

    typedef enum logic {
        FMT_I2S = 1'b0,
        FMT_LJ  = 1'b1
    } fmt_e;

    localparam int DEF_WORD_BITS = 24;
    localparam int DEF_SLOT_BITS = 32;

    localparam logic CH_LEFT  = 1'b0;
    localparam logic CH_RIGHT = 1'b1;

endpackage

// File: rtl/adc_iface_fifo.sv
// audio_word_fifo: 2-entry synchronous FIFO, head always in r_d0.
// A push into a full FIFO with no pop is dropped and flagged on o_drop;
// push and pop in the same cycle are both honoured at any fill level.
module audio_word_fifo #(
    parameter int DW = 25
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_push,
    input  logic [DW-1:0] i_data,
    input  logic          i_pop,
    output logic [DW-1:0] o_data,
    output logic          o_empty,
    output logic          o_full,
    output logic          o_drop
);

    logic [DW-1:0] r_d0, r_d1;
    logic [1:0]    r_cnt;
    logic          w_pop;

    assign w_pop   = i_pop && (r_cnt != 2'd0);
    assign o_data  = r_d0;
    assign o_empty = (r_cnt == 2'd0);
    assign o_full  = (r_cnt == 2'd2);
    assign o_drop  = i_push && o_full && !w_pop;

    // Fill-level driven storage update; entries shift toward r_d0 on pop.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= 2'd0;
            r_d0  <= '0;
            r_d1  <= '0;
        end else begin
            case (r_cnt)
                2'd0: begin
                    if (i_push) begin
                        r_d0  <= i_data;
                        r_cnt <= 2'd1;
                    end
                end
                2'd1: begin
                    case ({i_push, w_pop})
                        2'b11: r_d0 <= i_data;
                        2'b10: begin
                            r_d1  <= i_data;
                            r_cnt <= 2'd2;
                        end
                        2'b01: r_cnt <= 2'd0;
                        default: ;
                    endcase
                end
                2'd2: begin
                    if (w_pop) begin
                        r_d0 <= r_d1;
                        if (i_push) r_d1  <= i_data;
                        else        r_cnt <= 2'd1;
                    end
                end
                default: r_cnt <= 2'd0;
            endcase
        end
    end

endmodule

// File: rtl/adc_iface.sv
// adc_iface: clock-master receiver for an I2S / left-justified ADC.
// Generates bck/lrck, deserialises adata into WORD_BITS samples and
// buffers them in a 2-entry FIFO on a valid/ready stream.
// Optional: define ADC_IFACE_LJ_EN to allow mode[0]=1 (left-justified).
module adc_iface import adc_iface_pkg::*; #(
    parameter int BCK_DIV   = 4,
    parameter int WORD_BITS = DEF_WORD_BITS,
    parameter int SLOT_BITS = DEF_SLOT_BITS
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 adata,
    output logic                 bck,
    output logic                 lrck,
    input  logic [7:0]           mode,
    output logic                 word_valid,
    input  logic                 word_ready,
    output logic [WORD_BITS-1:0] data_word,
    output logic                 word_ch,
    output logic                 overflow
);

    localparam int DIV_W = (BCK_DIV > 1) ? $clog2(BCK_DIV) : 1;
    localparam int BIT_W = $clog2(SLOT_BITS);
    localparam logic [DIV_W-1:0] DIV_MAX  = DIV_W'(BCK_DIV - 1);
    localparam logic [BIT_W-1:0] SLOT_MAX = BIT_W'(SLOT_BITS - 1);
    localparam logic [BIT_W-1:0] I2S_LSB  = BIT_W'(WORD_BITS);

    logic [DIV_W-1:0]     r_div;
    logic [BIT_W-1:0]     r_bit;
    logic                 r_bck, r_lrck, r_ovf;
    logic [1:0]           r_sync;
    logic [WORD_BITS-1:0] r_sr;

    logic w_tick, w_fall, w_sdata, w_in_word, w_is_lsb, w_push;
    logic w_empty, w_full, w_drop, w_unused;
    logic [WORD_BITS:0] w_head;

    assign w_tick  = (r_div == DIV_MAX);
    assign w_fall  = w_tick && r_bck;
    assign w_sdata = r_sync[1];

`ifdef ADC_IFACE_LJ_EN
    localparam logic [BIT_W-1:0] LJ_LSB = BIT_W'(WORD_BITS - 1);
    fmt_e r_fmt;
    fmt_e w_fmt;
    logic w_lj;

    // Format follows mode during slot bit 0 of the left slot, then is frozen
    // for the rest of the frame.
    assign w_fmt     = (r_bit == '0 && r_lrck == CH_LEFT) ? fmt_e'(mode[0]) : r_fmt;
    assign w_lj      = (w_fmt == FMT_LJ);
    assign w_in_word = w_lj ? (r_bit <= LJ_LSB) : (r_bit != '0 && r_bit <= I2S_LSB);
    assign w_is_lsb  = (r_bit == (w_lj ? LJ_LSB : I2S_LSB));
    assign w_unused  = ^mode[7:1];

    // Hold the per-frame format.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_fmt <= FMT_I2S;
        else      r_fmt <= w_fmt;
    end
`else
    assign w_in_word = (r_bit != '0) && (r_bit <= I2S_LSB);
    assign w_is_lsb  = (r_bit == I2S_LSB);
    assign w_unused  = ^mode;
`endif

    assign w_push = w_fall && w_is_lsb;

    // bck half-period divider.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_div <= '0;
            r_bck <= 1'b0;
        end else begin
            r_div <= w_tick ? '0 : r_div + 1'b1;
            if (w_tick) r_bck <= ~r_bck;
        end
    end

    // Slot bit counter and lrck; both move only on bck falling edges.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_bit  <= '0;
            r_lrck <= CH_LEFT;
        end else if (w_fall) begin
            if (r_bit == SLOT_MAX) begin
                r_bit  <= '0;
                r_lrck <= ~r_lrck;
            end else begin
                r_bit <= r_bit + 1'b1;
            end
        end
    end

    // adata synchroniser; the falling-edge cycle sees the value from the bck-high phase.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_sync <= 2'b00;
        else      r_sync <= {r_sync[0], adata};
    end

    // MSB-first shift register over the active bits of the slot.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                   r_sr <= '0;
        else if (w_fall && w_in_word) r_sr <= {r_sr[WORD_BITS-2:0], w_sdata};
    end

    // Sticky drop flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)        r_ovf <= 1'b0;
        else if (w_drop) r_ovf <= 1'b1;
    end

    audio_word_fifo #(.DW(WORD_BITS + 1)) u_fifo (
        .i_clk   (clk),
        .i_rst_n (rst),
        .i_push  (w_push),
        .i_data  ({r_lrck, r_sr[WORD_BITS-2:0], w_sdata}),
        .i_pop   (word_valid && word_ready),
        .o_data  (w_head),
        .o_empty (w_empty),
        .o_full  (w_full),
        .o_drop  (w_drop)
    );

    assign bck        = r_bck;
    assign lrck       = r_lrck;
    assign word_valid = !w_empty;
    assign word_ch    = w_head[WORD_BITS];
    assign data_word  = w_head[WORD_BITS-1:0];
    assign overflow   = r_ovf;

endmodule

// File: tb/tb_adc_iface.sv
// Directed bench for adc_iface with a behavioural ADC that shifts queued
// words out on bck falling edges in I2S or left-justified framing.
module tb_adc_iface;

    localparam int BCK_DIV = 4;
    localparam int WB      = 24;
    localparam int SB      = 32;
`ifdef ADC_IFACE_LJ_EN
    localparam bit LJ_EN = 1'b1;
`else
    localparam bit LJ_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          adata = 1'b0;
    logic          word_ready = 1'b0;
    logic [7:0]    mode = 8'h00;
    logic          bck, lrck, word_valid, word_ch, overflow;
    logic [WB-1:0] data_word;

    adc_iface #(.BCK_DIV(BCK_DIV), .WORD_BITS(WB), .SLOT_BITS(SB)) dut (
        .clk        (clk),
        .rst        (rst),
        .adata      (adata),
        .bck        (bck),
        .lrck       (lrck),
        .mode       (mode),
        .word_valid (word_valid),
        .word_ready (word_ready),
        .data_word  (data_word),
        .word_ch    (word_ch),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int seen;

    // ADC model state
    logic [WB-1:0] txq[$];
    logic [WB-1:0] m_word;
    int            m_bit = 0;
    bit            m_ch = 1'b0;
    bit            m_fresh = 1'b1;
    bit            tb_lj = 1'b0;
    int            m_lsb_cnt = 0;

    function automatic logic tx_bit(input int b);
        if (tb_lj) return (b < WB) ? m_word[WB-1-b] : 1'b0;
        else       return (b >= 1 && b <= WB) ? m_word[WB-b] : 1'b0;
    endfunction

    // ADC: new bit after each bck fall, new slot word at each slot start.
    always @(negedge bck or rst) begin
        if (!rst) begin
            m_bit   = 0;
            m_ch    = 1'b0;
            m_fresh = 1'b1;
        end else if (m_fresh) begin
            m_fresh = 1'b0;
            m_word  = '0;
            if (txq.size() > 0) m_word = txq.pop_front();
            adata = tx_bit(0);
        end else begin
            if (m_bit == ((tb_lj && LJ_EN) ? WB-1 : WB)) m_lsb_cnt++;
            if (m_bit == SB-1) begin
                m_bit  = 0;
                m_ch   = !m_ch;
                m_word = '0;
                if (txq.size() > 0) m_word = txq.pop_front();
            end else begin
                m_bit++;
            end
            adata = tx_bit(m_bit);
        end
    end

    typedef struct {
        logic [7:0]    mode;
        logic [WB-1:0] l;
        logic [WB-1:0] r;
        logic [WB-1:0] exp_l;
        logic [WB-1:0] exp_r;
    } vec_t;
    vec_t vecs[5];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic timeout_fail(input string nm);
        checks++;
        errors++;
        $display("FAIL %s: timeout waiting for DUT", nm);
    endtask

    // Wait for the next LSB capture; returns at the first negedge after it.
    task automatic wait_lsb(input string nm);
        int n = 0;
        while (m_lsb_cnt <= seen && n < 4000) begin
            @(negedge clk);
            n++;
        end
        if (m_lsb_cnt <= seen) timeout_fail(nm);
        seen++;
    endtask

    task automatic expect_word(input string nm, input logic ch, input logic [WB-1:0] d);
        wait_lsb(nm);
        chk({nm, "_valid"}, word_valid, 1'b1);
        chk({nm, "_ch"}, word_ch, ch);
        chk({nm, "_data"}, data_word, d);
    endtask

    task automatic wait_model(input string nm, input int b, input bit ch);
        int n = 0;
        while (!(m_bit == b && m_ch == ch) && n < 4000) begin
            @(negedge clk);
            n++;
        end
        if (!(m_bit == b && m_ch == ch)) timeout_fail(nm);
    endtask

    task automatic reset_begin();
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        txq.delete();
    endtask

    task automatic reset_end();
        @(negedge clk);
        rst  = 1'b1;
        seen = m_lsb_cnt;
    endtask

    task automatic clkgen_check();
        int  r1, r2, l1, l2, bad;
        logic pb, pl;
        r1 = -1; r2 = -1; l1 = -1; l2 = -1; bad = 0;
        pb = bck; pl = lrck;
        for (int t = 0; t < 1100; t++) begin
            @(negedge clk);
            if (!pb && bck) begin
                if (r1 < 0) r1 = t; else if (r2 < 0) r2 = t;
            end
            if (lrck != pl) begin
                if (!(pb && !bck)) bad++;
                if (l1 < 0) l1 = t; else if (l2 < 0) l2 = t;
            end
            pb = bck;
            pl = lrck;
        end
        chk("bck_period", r2 - r1, 8);
        chk("lrck_period", 2 * (l2 - l1), 512);
        chk("lrck_at_bck_fall", bad, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{8'hFE, 24'hA5A5A5, 24'h123456, 24'hA5A5A5, 24'h123456};
        vecs[1] = '{8'h00, 24'hFFFFFF, 24'h000000, 24'hFFFFFF, 24'h000000};
        vecs[2] = '{8'h00, 24'h800000, 24'h000001, 24'h800000, 24'h000001};
        vecs[3] = '{8'h00, 24'h5A5A5A, 24'hC3C3C3, 24'h5A5A5A, 24'hC3C3C3};
`ifdef ADC_IFACE_LJ_EN
        vecs[4] = '{8'h01, 24'h800001, 24'h7FFFFE, 24'h800001, 24'h7FFFFE};
`else
        vecs[4] = '{8'h01, 24'h800001, 24'h7FFFFE, 24'h000002, 24'hFFFFFC};
`endif

        #1 rst = 1'b0;
        word_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_bck", bck, 1'b0);
        chk("rst_lrck", lrck, 1'b0);
        chk("rst_valid", word_valid, 1'b0);
        chk("rst_data", data_word, 24'h0);
        chk("rst_ch", word_ch, 1'b0);
        chk("rst_ovf", overflow, 1'b0);

        // Clock generation over two frames
        reset_end();
        clkgen_check();

        // Loopback vectors, ready held high
        for (int i = 0; i < 5; i++) begin
            reset_begin();
            mode  = vecs[i].mode;
            tb_lj = vecs[i].mode[0];
            txq.push_back(vecs[i].l);
            txq.push_back(vecs[i].r);
            word_ready = 1'b1;
            reset_end();
            expect_word($sformatf("v%0d_L", i), 1'b0, vecs[i].exp_l);
            expect_word($sformatf("v%0d_R", i), 1'b1, vecs[i].exp_r);
        end
        mode  = 8'h00;
        tb_lj = 1'b0;

        // Backpressure: third word dropped, overflow sticky
        reset_begin();
        word_ready = 1'b0;
        txq.push_back(24'h111111); txq.push_back(24'h222222);
        txq.push_back(24'h333333); txq.push_back(24'h444444);
        reset_end();
        wait_lsb("bp1");
        wait_lsb("bp2");
        chk("bp_ovf_full", overflow, 1'b0);
        chk("bp_valid_full", word_valid, 1'b1);
        wait_lsb("bp3");
        chk("bp_ovf_drop", overflow, 1'b1);
        chk("bp_head_data", data_word, 24'h111111);
        chk("bp_head_ch", word_ch, 1'b0);
        word_ready = 1'b1;
        @(negedge clk);
        chk("bp_second_data", data_word, 24'h222222);
        chk("bp_second_ch", word_ch, 1'b1);
        @(negedge clk);
        chk("bp_drained", word_valid, 1'b0);
        chk("bp_ovf_sticky", overflow, 1'b1);

        // Full FIFO, pop on the push cycle
        reset_begin();
        word_ready = 1'b0;
        txq.push_back(24'hAAAAAA); txq.push_back(24'hBBBBBB); txq.push_back(24'hCCCCCC);
        reset_end();
        wait_lsb("pp1");
        wait_lsb("pp2");
        wait_model("pp_align", WB, 1'b0);
        repeat (7) @(negedge clk);
        word_ready = 1'b1;
        @(negedge clk);
        chk("pp_ovf", overflow, 1'b0);
        chk("pp_valid", word_valid, 1'b1);
        chk("pp_head_data", data_word, 24'hBBBBBB);
        chk("pp_head_ch", word_ch, 1'b1);
        @(negedge clk);
        chk("pp_tail_data", data_word, 24'hCCCCCC);
        chk("pp_tail_ch", word_ch, 1'b0);
        @(negedge clk);
        chk("pp_empty", word_valid, 1'b0);
        chk("pp_ovf_end", overflow, 1'b0);

        // Reset mid-word at left slot bit 10 with buffered data
        reset_begin();
        word_ready = 1'b0;
        txq.push_back(24'h111111); txq.push_back(24'h222222); txq.push_back(24'h333333);
        reset_end();
        wait_lsb("rm1");
        wait_lsb("rm2");
        wait_model("rm_align", 10, 1'b0);
        repeat (4) @(negedge clk);
        chk("rm_pre_bck", bck, 1'b1);
        chk("rm_pre_valid", word_valid, 1'b1);
        rst = 1'b0;
        #1;
        chk("rm_bck", bck, 1'b0);
        chk("rm_lrck", lrck, 1'b0);
        chk("rm_valid", word_valid, 1'b0);
        chk("rm_data", data_word, 24'h0);
        chk("rm_ch", word_ch, 1'b0);
        repeat (2) @(negedge clk);
        txq.delete();
        txq.push_back(24'h654321); txq.push_back(24'h0FEDCB);
        word_ready = 1'b1;
        reset_end();
        expect_word("rm_L", 1'b0, 24'h654321);
        expect_word("rm_R", 1'b1, 24'h0FEDCB);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
